// File: rtl/pixel_op_pkg.sv
// Shared definitions for the pixel point-operation unit: mode codes,
// frame FSM states and the per-pixel frame-position sideband.
package pixel_op_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_OFS  = 2'd2;
    localparam logic [1:0] MODE_THR  = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } sideband_t;

endpackage

// File: rtl/pixel_chan_op.sv
// Combinational point operation on a single channel value.
// The offset is a signed DATA_W+1 bit quantity; the sum is formed two bits
// wider than a channel so both underflow and overflow are visible before
// clamping.
module pixel_chan_op
    import pixel_op_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W:0]   offset,
    input  logic [DATA_W-1:0] thresh,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);

    localparam logic [DATA_W-1:0] MAX = '1;

    logic signed [DATA_W+1:0] sum;

    // Select the channel result for the active mode, clamping the offset sum to [0, MAX]
    always_comb begin
        sum = $signed({2'b00, x}) + $signed({offset[DATA_W], offset});
        y   = x;
        case (mode)
            MODE_PASS: y = x;
            MODE_INV:  y = MAX - x;
            MODE_OFS: begin
                if (sum[DATA_W+1]) begin
                    y = '0;
                end else if (sum[DATA_W]) begin
                    y = MAX;
                end else begin
                    y = sum[DATA_W-1:0];
                end
            end
            MODE_THR:  y = (x >= thresh) ? MAX : '0;
        endcase
    end

endmodule

// File: rtl/pixel_point_op.sv
// Streaming per-pixel point operation with valid/ready backpressure.
// Stage 1 registers the accepted pixel, its frame markers and the config
// that applies to its frame; stage 2 registers the per-channel result.
// Config is shadowed on the first accept of a frame so mid-frame changes
// only land on the next frame.
module pixel_point_op
    import pixel_op_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 cfg_mode,
    input  logic [DATA_W:0]            cfg_offset,
    input  logic [DATA_W-1:0]          cfg_thresh,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [CHANNELS*DATA_W-1:0] s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CHANNELS*DATA_W-1:0] m_data,
    output logic                       m_sof,
    output logic                       m_eol,
    output logic                       m_eof,
    output logic                       busy
);

    localparam int PIX_W = CHANNELS * DATA_W;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_e state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic [1:0]        shd_mode_q, shd_mode_d;
    logic [DATA_W:0]   shd_ofs_q, shd_ofs_d;
    logic [DATA_W-1:0] shd_thr_q, shd_thr_d;

    logic              v1_q, v1_d;
    logic [PIX_W-1:0]  d1_q, d1_d;
    sideband_t         sb1_q, sb1_d;
    logic [1:0]        mode1_q, mode1_d;
    logic [DATA_W:0]   ofs1_q, ofs1_d;
    logic [DATA_W-1:0] thr1_q, thr1_d;

    logic              m_valid_q, m_valid_d;
    logic [PIX_W-1:0]  m_data_q, m_data_d;
    sideband_t         sb2_q, sb2_d;

    logic              en;
    logic              accept;
    logic              idle_accept;
    logic              last_col;
    logic              last_row;
    sideband_t         in_sb;
    logic [PIX_W-1:0]  op_data;

    // Handshake: the whole pipeline moves when the output slot is free or draining
    always_comb begin
        en          = !m_valid_q || m_ready;
        s_ready     = rst && en;
        accept      = s_valid && s_ready;
        idle_accept = accept && (state_q == IDLE);
        last_col    = (col_q == COL_LAST);
        last_row    = (row_q == ROW_LAST);
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next state: any accept opens a frame, the last pixel closes it
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = (last_col && last_row) ? IDLE : ACTIVE;
        end
    end

    // Frame FSM outputs: busy flag and markers for the pixel being accepted
    always_comb begin
        busy      = (state_q == ACTIVE);
        in_sb.sof = (state_q == IDLE);
        in_sb.eol = last_col;
        in_sb.eof = last_col && last_row;
    end

    // Column/row position advances only on accept
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Config shadow is loaded from the live inputs only when a frame starts
    always_comb begin
        shd_mode_d = shd_mode_q;
        shd_ofs_d  = shd_ofs_q;
        shd_thr_d  = shd_thr_q;
        if (idle_accept) begin
            shd_mode_d = cfg_mode;
            shd_ofs_d  = cfg_offset;
            shd_thr_d  = cfg_thresh;
        end
    end

    // Per-channel operation on the stage-1 pixel
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pixel_chan_op #(
            .DATA_W (DATA_W)
        ) u_chan (
            .mode   (mode1_q),
            .offset (ofs1_q),
            .thresh (thr1_q),
            .x      (d1_q[c*DATA_W +: DATA_W]),
            .y      (op_data[c*DATA_W +: DATA_W])
        );
    end

    // Pipeline next values; the first pixel of a frame uses the live config it shadows
    always_comb begin
        v1_d      = v1_q;
        d1_d      = d1_q;
        sb1_d     = sb1_q;
        mode1_d   = mode1_q;
        ofs1_d    = ofs1_q;
        thr1_d    = thr1_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        sb2_d     = sb2_q;
        if (en) begin
            v1_d      = accept;
            d1_d      = s_data;
            sb1_d     = accept ? in_sb : '0;
            mode1_d   = idle_accept ? cfg_mode   : shd_mode_q;
            ofs1_d    = idle_accept ? cfg_offset : shd_ofs_q;
            thr1_d    = idle_accept ? cfg_thresh : shd_thr_q;
            m_valid_d = v1_q;
            m_data_d  = op_data;
            sb2_d     = sb1_q;
        end
    end

    // Position counters and config shadow registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            shd_mode_q <= MODE_PASS;
            shd_ofs_q  <= '0;
            shd_thr_q  <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            shd_mode_q <= shd_mode_d;
            shd_ofs_q  <= shd_ofs_d;
            shd_thr_q  <= shd_thr_d;
        end
    end

    // Two pipeline stages; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            d1_q      <= '0;
            sb1_q     <= '0;
            mode1_q   <= MODE_PASS;
            ofs1_q    <= '0;
            thr1_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            sb2_q     <= '0;
        end else begin
            v1_q      <= v1_d;
            d1_q      <= d1_d;
            sb1_q     <= sb1_d;
            mode1_q   <= mode1_d;
            ofs1_q    <= ofs1_d;
            thr1_q    <= thr1_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            sb2_q     <= sb2_d;
        end
    end

    // Output port mapping
    always_comb begin
        m_valid = m_valid_q;
        m_data  = m_data_q;
        m_sof   = sb2_q.sof;
        m_eol   = sb2_q.eol;
        m_eof   = sb2_q.eof;
    end

endmodule
